// File: rtl/scramble.sv
// scramble: 100BASE-X PCS transmit stream scrambler (key stream x^11 + x^9 + 1).
// Every enable is followed by a run of scrambled idle bits, so the far-end
// descrambler can lock before real data flows. Two bits are processed per clock,
// and bit [1] is the earlier one in time. The output is registered, so latency is
// one cycle.
// Optional feature: define SCRAMBLE_BYPASS_EN to add the `bypass` input. While
// bypass is high in RUN, data passes through unscrambled and the LFSR keeps
// advancing.
module scramble #(
    parameter logic [10:0] SEED         = 11'h7ff,
    parameter int          PREFILL_BITS = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [1:0] unscrambled,
    input  logic [1:0] unscrambled_valid,
`ifdef SCRAMBLE_BYPASS_EN
    input  logic       bypass,
`endif
    output logic [1:0] scrambled,
    output logic [1:0] scrambled_valid,
    output logic       ready
);

    // An all-zero LFSR would lock up, so a zero seed falls back to all ones.
    localparam logic [10:0] SEED_EFF     = (SEED == 11'h000) ? 11'h7ff : SEED;
    localparam logic [6:0]  PREFILL_INIT = 7'(PREFILL_BITS);

    typedef enum logic [1:0] {DISABLED, PREFILL, RUN} state_t;

    state_t      state;
    logic [10:0] lfsr;
    logic [6:0]  cnt;

    logic [1:0]  vld_p0;
    logic [1:0]  nbits_p0;
    logic [1:0]  key_p0;
    logic [1:0]  data_p0;
    logic [1:0]  out_p0;
    logic        byp_p0;
    logic [10:0] lfsr_nxt_p0;
    logic [6:0]  cnt_nxt_p0;

    // Saturating decrement of the prefill counter by the number of valid bits.
    function automatic logic [6:0] sat_dec(input logic [6:0] c, input logic [1:0] n);
        logic [6:0] n7;
        n7 = {5'd0, n};
        return (c > n7) ? (c - n7) : 7'd0;
    endfunction

    // Input qualification, key stream, idle substitution and next LFSR/counter.
    always_comb begin
        vld_p0      = 2'b00;
        nbits_p0    = 2'd0;
        lfsr_nxt_p0 = lfsr;
        case (unscrambled_valid)
            2'b00:   begin vld_p0 = 2'b00; nbits_p0 = 2'd0; end
            2'b10:   begin vld_p0 = 2'b10; nbits_p0 = 2'd2; end
            default: begin vld_p0 = 2'b01; nbits_p0 = 2'd1; end
        endcase
        // k[1] goes with the earlier bit. k[0] equals the next serial key bit,
        // so a two-bit step matches two one-bit steps.
        key_p0 = {lfsr[10] ^ lfsr[8], lfsr[9] ^ lfsr[7]};
        case (vld_p0)
            2'b10:   lfsr_nxt_p0 = {lfsr[8:0], key_p0};
            2'b01:   lfsr_nxt_p0 = {lfsr[9:0], key_p0[1]};
            default: lfsr_nxt_p0 = lfsr;
        endcase
        data_p0 = (state == PREFILL) ? 2'b11 : unscrambled;
`ifdef SCRAMBLE_BYPASS_EN
        byp_p0 = bypass && (state == RUN);
`else
        byp_p0 = 1'b0;
`endif
        out_p0     = byp_p0 ? data_p0 : (data_p0 ^ key_p0);
        cnt_nxt_p0 = sat_dec(cnt, nbits_p0);
    end

    // Control FSM with registered outputs; enable low always returns to DISABLED.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= DISABLED;
            lfsr            <= SEED_EFF;
            cnt             <= PREFILL_INIT;
            scrambled       <= 2'b00;
            scrambled_valid <= 2'b00;
            ready           <= 1'b0;
        end else if (!enable) begin
            state           <= DISABLED;
            lfsr            <= SEED_EFF;
            cnt             <= PREFILL_INIT;
            scrambled       <= 2'b00;
            scrambled_valid <= 2'b00;
            ready           <= 1'b0;
        end else begin
            case (state)
                DISABLED: begin
                    state           <= PREFILL;
                    lfsr            <= SEED_EFF;
                    cnt             <= PREFILL_INIT;
                    scrambled       <= 2'b00;
                    scrambled_valid <= 2'b00;
                    ready           <= 1'b0;
                end
                PREFILL: begin
                    lfsr            <= lfsr_nxt_p0;
                    cnt             <= cnt_nxt_p0;
                    scrambled_valid <= vld_p0;
                    ready           <= 1'b0;
                    if (vld_p0 != 2'b00) scrambled <= out_p0;
                    if (cnt_nxt_p0 == 7'd0) state <= RUN;
                end
                RUN: begin
                    lfsr            <= lfsr_nxt_p0;
                    scrambled_valid <= vld_p0;
                    ready           <= 1'b1;
                    if (vld_p0 != 2'b00) scrambled <= out_p0;
                end
                default: begin
                    state           <= DISABLED;
                    lfsr            <= SEED_EFF;
                    cnt             <= PREFILL_INIT;
                    scrambled       <= 2'b00;
                    scrambled_valid <= 2'b00;
                    ready           <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scramble.sv
// tb_scramble: directed bench for scramble, with a serial key-stream reference model.
// Instance u_dut uses the default 64-bit prefill; u_odd uses PREFILL_BITS=63.
module tb_scramble;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable, enable2;
    logic [1:0] din, dvld, din2, dvld2;
    logic [1:0] dout, dovld, dout2, dovld2;
    logic       rdy, rdy2;
`ifdef SCRAMBLE_BYPASS_EN
    logic       bypass;
`endif

    int          nvec = 0;
    int          nerr = 0;
    logic [10:0] ml;
    logic        last1;

    always #4 clk = ~clk;

    scramble u_dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .unscrambled(din), .unscrambled_valid(dvld),
`ifdef SCRAMBLE_BYPASS_EN
        .bypass(bypass),
`endif
        .scrambled(dout), .scrambled_valid(dovld), .ready(rdy)
    );

    scramble #(.PREFILL_BITS(63)) u_odd (
        .clk(clk), .rst_n(rst_n), .enable(enable2),
        .unscrambled(din2), .unscrambled_valid(dvld2),
`ifdef SCRAMBLE_BYPASS_EN
        .bypass(1'b0),
`endif
        .scrambled(dout2), .scrambled_valid(dovld2), .ready(rdy2)
    );

    // Serial reference: one key bit per time step, taps x^11 + x^9.
    task automatic key_step(output logic kb);
        kb = ml[10] ^ ml[8];
        ml = {ml[9:0], kb};
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; enable = 1'b0; enable2 = 1'b0;
        din = 2'b00; dvld = 2'b00; din2 = 2'b00; dvld2 = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        nvec++; if (dout !== 2'b00)  begin nerr++; $display("FAIL reset_scrambled got %b want 00", dout); end
        nvec++; if (dovld !== 2'b00) begin nerr++; $display("FAIL reset_valid got %b want 00", dovld); end
        nvec++; if (rdy !== 1'b0)    begin nerr++; $display("FAIL reset_ready got %b want 0", rdy); end
        rst_n = 1'b1;
        cyc;
    endtask

    task automatic test_prefill;
        logic kb, k1, k0;
        enable = 1'b1; dvld = 2'b01; din = 2'b00;
        cyc;
        nvec++; if (dovld !== 2'b00) begin nerr++; $display("FAIL prefill_entry_valid got %b want 00", dovld); end
        ml = 11'h7ff;
        for (int i = 0; i < 64; i++) begin
            key_step(kb);
            cyc;
            nvec++;
            if (dovld !== 2'b01 || dout[1] !== ~kb || rdy !== 1'b0) begin
                nerr++;
                $display("FAIL prefill_bit%0d got vld=%b bit=%b rdy=%b want vld=01 bit=%b rdy=0", i, dovld, dout[1], rdy, ~kb);
            end
        end
        key_step(kb);
        cyc;
        nvec++;
        if (dovld !== 2'b01 || dout[1] !== kb || rdy !== 1'b1) begin
            nerr++;
            $display("FAIL first_run_bit got vld=%b bit=%b rdy=%b want vld=01 bit=%b rdy=1", dovld, dout[1], rdy, kb);
        end
        din = 2'b10; dvld = 2'b10;
        key_step(k1); key_step(k0);
        cyc;
        nvec++;
        if (dovld !== 2'b10 || dout !== (2'b10 ^ {k1, k0})) begin
            nerr++;
            $display("FAIL run_two_bits got vld=%b out=%b want vld=10 out=%b", dovld, dout, 2'b10 ^ {k1, k0});
        end
        din = 2'b01; dvld = 2'b11;
        key_step(kb);
        cyc;
        nvec++;
        if (dovld !== 2'b01 || dout[1] !== kb) begin
            nerr++;
            $display("FAIL valid11_as_01 got vld=%b bit=%b want vld=01 bit=%b", dovld, dout[1], kb);
        end
        last1 = kb;
        dvld = 2'b00;
        cyc;
        nvec++;
        if (dovld !== 2'b00 || dout[1] !== last1 || rdy !== 1'b1) begin
            nerr++;
            $display("FAIL idle_hold got vld=%b bit=%b rdy=%b want vld=00 bit=%b rdy=1", dovld, dout[1], rdy, last1);
        end
    endtask

    task automatic test_round_trip;
        logic k1, k0;
        int   r;
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 2);
            dvld = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b10;
            din = 2'($urandom);
            k1 = 1'b0; k0 = 1'b0;
            if (dvld == 2'b10) begin key_step(k1); key_step(k0); end
            else if (dvld == 2'b01) key_step(k1);
            cyc;
            nvec++;
            if (dvld == 2'b10) begin
                if (dovld !== 2'b10 || (dout ^ {k1, k0}) !== din) begin
                    nerr++;
                    $display("FAIL round_trip%0d got vld=%b desc=%b want vld=10 data=%b", i, dovld, dout ^ {k1, k0}, din);
                end
                last1 = din[1] ^ k1;
            end else if (dvld == 2'b01) begin
                if (dovld !== 2'b01 || (dout[1] ^ k1) !== din[1]) begin
                    nerr++;
                    $display("FAIL round_trip%0d got vld=%b desc=%b want vld=01 data=%b", i, dovld, dout[1] ^ k1, din[1]);
                end
                last1 = din[1] ^ k1;
            end else begin
                if (dovld !== 2'b00 || dout[1] !== last1) begin
                    nerr++;
                    $display("FAIL round_trip_idle%0d got vld=%b bit=%b want vld=00 bit=%b", i, dovld, dout[1], last1);
                end
            end
        end
    endtask

`ifdef SCRAMBLE_BYPASS_EN
    task automatic test_bypass;
        logic k1, k0;
        bypass = 1'b1; dvld = 2'b10;
        for (int i = 0; i < 10; i++) begin
            din = 2'($urandom);
            key_step(k1); key_step(k0);
            cyc;
            nvec++;
            if (dovld !== 2'b10 || dout !== din) begin
                nerr++;
                $display("FAIL bypass%0d got %b want %b", i, dout, din);
            end
        end
        bypass = 1'b0;
        for (int i = 0; i < 10; i++) begin
            din = 2'($urandom);
            key_step(k1); key_step(k0);
            cyc;
            nvec++;
            if (dout !== (din ^ {k1, k0})) begin
                nerr++;
                $display("FAIL post_bypass%0d got %b want %b", i, dout, din ^ {k1, k0});
            end
        end
    endtask
`endif

    task automatic test_enable_drop;
        logic kb;
        enable = 1'b0; dvld = 2'b01; din = 2'b00;
        cyc;
        nvec++;
        if (dovld !== 2'b00 || rdy !== 1'b0 || dout !== 2'b00) begin
            nerr++;
            $display("FAIL drop_clear got vld=%b rdy=%b out=%b want vld=00 rdy=0 out=00", dovld, rdy, dout);
        end
        enable = 1'b1;
        cyc;
        nvec++; if (dovld !== 2'b00) begin nerr++; $display("FAIL drop_reentry_valid got %b want 00", dovld); end
        ml = 11'h7ff;
        for (int i = 0; i < 64; i++) begin
            key_step(kb);
            cyc;
            nvec++;
            if (dovld !== 2'b01 || dout[1] !== ~kb || rdy !== 1'b0) begin
                nerr++;
                $display("FAIL drop_prefill%0d got vld=%b bit=%b rdy=%b want vld=01 bit=%b rdy=0", i, dovld, dout[1], rdy, ~kb);
            end
        end
        key_step(kb);
        cyc;
        nvec++;
        if (rdy !== 1'b1 || dout[1] !== kb) begin
            nerr++;
            $display("FAIL drop_ready got rdy=%b bit=%b want rdy=1 bit=%b", rdy, dout[1], kb);
        end
    endtask

    task automatic test_reset_mid;
        logic kb;
        dvld = 2'b10; din = 2'b11;
        repeat (2) cyc;
        rst_n = 1'b0;
        #2;
        nvec++;
        if (dout !== 2'b00 || dovld !== 2'b00 || rdy !== 1'b0) begin
            nerr++;
            $display("FAIL mid_reset got out=%b vld=%b rdy=%b want 00 00 0", dout, dovld, rdy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        dvld = 2'b01; din = 2'b00;
        cyc;
        ml = 11'h7ff;
        for (int i = 0; i < 12; i++) begin
            key_step(kb);
            cyc;
            nvec++;
            if (dovld !== 2'b01 || dout[1] !== ~kb) begin
                nerr++;
                $display("FAIL mid_reset_reseed%0d got vld=%b bit=%b want vld=01 bit=%b", i, dovld, dout[1], ~kb);
            end
        end
        enable = 1'b0; dvld = 2'b00;
        cyc;
    endtask

    task automatic test_odd_boundary;
        logic k1, k0;
        enable2 = 1'b1; dvld2 = 2'b10; din2 = 2'b00;
        cyc;
        nvec++; if (dovld2 !== 2'b00) begin nerr++; $display("FAIL odd_entry_valid got %b want 00", dovld2); end
        ml = 11'h7ff;
        for (int i = 0; i < 32; i++) begin
            key_step(k1); key_step(k0);
            cyc;
            nvec++;
            if (dovld2 !== 2'b10 || dout2 !== ~{k1, k0} || rdy2 !== 1'b0) begin
                nerr++;
                $display("FAIL odd_prefill%0d got vld=%b out=%b rdy=%b want vld=10 out=%b rdy=0", i, dovld2, dout2, rdy2, ~{k1, k0});
            end
        end
        key_step(k1); key_step(k0);
        cyc;
        nvec++;
        if (rdy2 !== 1'b1 || dout2 !== {k1, k0}) begin
            nerr++;
            $display("FAIL odd_ready got rdy=%b out=%b want rdy=1 out=%b", rdy2, dout2, {k1, k0});
        end
        enable2 = 1'b0;
        cyc;
    endtask

    initial begin
`ifdef SCRAMBLE_BYPASS_EN
        bypass = 1'b0;
`endif
        test_reset;
        test_prefill;
        test_round_trip;
`ifdef SCRAMBLE_BYPASS_EN
        test_bypass;
`endif
        test_enable_drop;
        test_reset_mid;
        test_odd_boundary;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
